sd_sector_arbiter: RTL

//  Shares the single SD-over-SPI sector-read engine between two requesters: video frame fetch and audio fetch.

---
 rtl/sd_sector_arbiter.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/sd_sector_arbiter.sv
// Arbitrates the single SD-over-SPI sector-read engine between video and audio fetch.
// Define AUDIO_PRIORITY_EN for strict audio priority; the default build is round-robin.
module sd_sector_arbiter #(
    parameter int unsigned SECTOR_BYTES   = 512,
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic              DataClock,
    input  logic              Reset,
    input  logic              VidReq,
    input  logic [ADDR_W-1:0] VidAddr,
    output logic              VidGrant,
    output logic              VidByteValid,
    output logic              VidDone,
    input  logic              AudReq,
    input  logic [ADDR_W-1:0] AudAddr,
    output logic              AudGrant,
    output logic              AudByteValid,
    output logic              AudDone,
    input  logic              CoreReady,
    output logic              CoreStart,
    output logic [ADDR_W-1:0] CoreAddr,
    input  logic              CoreDataValid,
    input  logic [7:0]        CoreData,
    output logic [7:0]        ByteOut,
    output logic [8:0]        ByteIndex,
    output logic              Timeout
);
    localparam int unsigned      TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]       BYTE_LAST = 10'(SECTOR_BYTES - 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_DATA, XFER, DONE} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] core_addr_q, core_addr_d;
    logic              core_start_q, core_start_d;
    logic              vid_grant_q, vid_grant_d;
    logic              aud_grant_q, aud_grant_d;
    logic              vid_bv_q, vid_bv_d;
    logic              aud_bv_q, aud_bv_d;
    logic              vid_done_q, vid_done_d;
    logic              aud_done_q, aud_done_d;
    logic [7:0]        byte_out_q, byte_out_d;
    logic [8:0]        byte_index_q, byte_index_d;
    logic              timeout_q, timeout_d;
    logic [9:0]        byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic              last_aud_q, last_aud_d;
    logic              pick_aud;
    logic              fwd;

    always_comb begin
        state_d      = state_q;
        core_addr_d  = core_addr_q;
        core_start_d = 1'b0;
        vid_grant_d  = vid_grant_q;
        aud_grant_d  = aud_grant_q;
        vid_bv_d     = 1'b0;
        aud_bv_d     = 1'b0;
        vid_done_d   = 1'b0;
        aud_done_d   = 1'b0;
        byte_out_d   = byte_out_q;
        byte_index_d = byte_index_q;
        timeout_d    = timeout_q;
        byte_cnt_d   = byte_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        last_aud_d   = last_aud_q;
        fwd          = 1'b0;
`ifdef AUDIO_PRIORITY_EN
        pick_aud = AudReq;
`else
        // On a tie the requester not served last wins.
        pick_aud = AudReq && (!VidReq || !last_aud_q);
`endif

        case (state_q)
            IDLE: begin
                if (VidReq || AudReq) begin
                    aud_grant_d = pick_aud;
                    vid_grant_d = !pick_aud;
                    core_addr_d = pick_aud ? AudAddr : VidAddr;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (CoreReady) begin
                    core_start_d = 1'b1;
                    state_d      = WAIT_DATA;
                end
            end
            WAIT_DATA: begin
                if (CoreDataValid) begin
                    fwd = 1'b1;
                end else if (tmo_cnt_q == TMO_LAST) begin
                    timeout_d  = 1'b1;
                    vid_done_d = vid_grant_q;
                    aud_done_d = aud_grant_q;
                    state_d    = DONE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            XFER: fwd = CoreDataValid;
            DONE: begin
                vid_grant_d = 1'b0;
                aud_grant_d = 1'b0;
                last_aud_d  = aud_grant_q;
                byte_cnt_d  = '0;
                tmo_cnt_d   = '0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Done is raised on entry to DONE so it coincides with the last byte.
        if (fwd) begin
            byte_out_d   = CoreData;
            byte_index_d = byte_cnt_q[8:0];
            vid_bv_d     = vid_grant_q;
            aud_bv_d     = aud_grant_q;
            byte_cnt_d   = byte_cnt_q + 1'b1;
            if (byte_cnt_q == BYTE_LAST) begin
                vid_done_d = vid_grant_q;
                aud_done_d = aud_grant_q;
                state_d    = DONE;
            end else begin
                state_d = XFER;
            end
        end
    end

    always_ff @(posedge DataClock) begin
        if (Reset) begin
            state_q      <= IDLE;
            core_addr_q  <= '0;
            core_start_q <= 1'b0;
            vid_grant_q  <= 1'b0;
            aud_grant_q  <= 1'b0;
            vid_bv_q     <= 1'b0;
            aud_bv_q     <= 1'b0;
            vid_done_q   <= 1'b0;
            aud_done_q   <= 1'b0;
            byte_out_q   <= '0;
            byte_index_q <= '0;
            timeout_q    <= 1'b0;
            byte_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
            last_aud_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            core_addr_q  <= core_addr_d;
            core_start_q <= core_start_d;
            vid_grant_q  <= vid_grant_d;
            aud_grant_q  <= aud_grant_d;
            vid_bv_q     <= vid_bv_d;
            aud_bv_q     <= aud_bv_d;
            vid_done_q   <= vid_done_d;
            aud_done_q   <= aud_done_d;
            byte_out_q   <= byte_out_d;
            byte_index_q <= byte_index_d;
            timeout_q    <= timeout_d;
            byte_cnt_q   <= byte_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            last_aud_q   <= last_aud_d;
        end
    end

    assign VidGrant     = vid_grant_q;
    assign AudGrant     = aud_grant_q;
    assign VidByteValid = vid_bv_q;
    assign AudByteValid = aud_bv_q;
    assign VidDone      = vid_done_q;
    assign AudDone      = aud_done_q;
    assign CoreStart    = core_start_q;
    assign CoreAddr     = core_addr_q;
    assign ByteOut      = byte_out_q;
    assign ByteIndex    = byte_index_q;
    assign Timeout      = timeout_q;
endmodule
